// File: rtl/fp_to_linear.sv
// Decodes the 8-bit float (sign, 3-bit exponent, 4-bit significand) to a 12-bit
// two's-complement value by shifting the significand left once per clock.
module fp_to_linear (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [2:0]  exp,
    input  logic [3:0]  sig,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] d
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_r_q, sign_r_d;
    logic [10:0] mag_q, mag_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] d_q, d_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    always_comb begin
        state_d  = state_q;
        sign_r_d = sign_r_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_r_d = sign;
                    mag_d    = {7'b0, sig};
                    cnt_d    = exp;
                    state_d  = (exp == 3'd0) ? FIX : SHIFT;
                end
            end
            SHIFT: begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = FIX;
            end
            FIX: begin
                // Magnitude never exceeds 1920, so the 12-bit negation cannot reach 12'h800.
                d_d     = sign_r_q ? (~{1'b0, mag_q} + 12'd1) : {1'b0, mag_q};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_r_q    <= 1'b0;
            mag_q       <= 11'd0;
            cnt_q       <= 3'd0;
            d_q         <= 12'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_r_q    <= sign_r_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;

endmodule

// File: tb/tb_fp_to_linear.sv
// Directed bench for fp_to_linear: latency, sign handling, backpressure and async reset.
module tb_fp_to_linear;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign = 1'b0;
    logic [2:0]  exp = 3'd0;
    logic [3:0]  sig = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] d;

    int n_chk = 0;
    int n_fail = 0;

    fp_to_linear dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp), .sig(sig), .out_valid(out_valid),
        .out_ready(out_ready), .d(d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one word at a negedge, then count edges until out_valid (bounded).
    task automatic run_word(input string tag, input logic s, input logic [2:0] e,
                            input logic [3:0] g, input logic [11:0] expd);
        int lat;
        lat = 99;
        @(negedge clk);
        sign = s; exp = e; sig = g; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        if (out_valid) lat = 0;
        for (int i = 1; i <= 20 && lat == 99; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) lat = i;
        end
        chk({tag, "_lat"}, lat, e + 1);
        chk({tag, "_d"}, {20'd0, d}, {20'd0, expd});
        chk({tag, "_excl"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic drain(input string tag, input logic [11:0] expd);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_d_hold"}, {20'd0, d}, {20'd0, expd});
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", {20'd0, d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word("p0_1", 1'b0, 3'd0, 4'd1, 12'h001);
        drain("p0_1", 12'h001);
        run_word("p7_15", 1'b0, 3'd7, 4'd15, 12'h780);
        drain("p7_15", 12'h780);
        run_word("n7_15", 1'b1, 3'd7, 4'd15, 12'h880);
        drain("n7_15", 12'h880);
        run_word("n2_5", 1'b1, 3'd2, 4'd5, 12'hFEC);
        drain("n2_5", 12'hFEC);
        run_word("negzero", 1'b1, 3'd3, 4'd0, 12'h000);
        drain("negzero", 12'h000);

        // Backpressure: DONE held while new words are offered and must be ignored.
        out_ready = 1'b0;
        run_word("bp", 1'b0, 3'd2, 4'd3, 12'h00C);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sign = i[0]; exp = i[2:0]; sig = 4'(i + 7);
            @(posedge clk);
            @(negedge clk);
            chk("bp_d", {20'd0, d}, 32'h00C);
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp", 12'h00C);

        // Reset asserted shortly after shift edge 3 of an exp=6 word.
        @(negedge clk);
        sign = 1'b0; exp = 3'd6; sig = 4'd1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_d", {20'd0, d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("post_rst", 1'b0, 3'd1, 4'd3, 12'h006);
        drain("post_rst", 12'h006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
